// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use hazard / forwarding controller.
package hazard_pkg;

  // One in-flight instruction's destination tag as tracked down the pipeline.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } tag_slot_t;

  // Forward-select code meaning "take the operand from the register file".
  localparam int unsigned FWD_REGFILE = 0;

  // Width of one forward-select field for a given number of extra memory stages.
  function automatic int unsigned fwd_w(input int unsigned lat);
    return $clog2(lat + 3);
  endfunction

endpackage

// File: rtl/haz_tag_pipe.sv
// Destination-tag shift register mirroring EX, MEM0..MEM[LOAD_LAT] and WB.
// Slot 0 is EX, the last slot is WB; a bubble clears the tag entering EX.
module haz_tag_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      bubble_i,
  input  tag_slot_t slot_i,
  output tag_slot_t slots_o [DEPTH]
);

  tag_slot_t slot_q [DEPTH];

  // Shift every tag one stage toward WB; the WB tag falls off the end.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q[0] <= bubble_i ? tag_slot_t'('0) : slot_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  assign slots_o = slot_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and EX-stage forwarding select generation.
// Optional performance counters (stall_cnt, flush_cnt) exist only when the
// HAZ_PERF_CNT_EN macro is defined.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned NSRC     = 2,
  parameter  int unsigned LOAD_LAT = 0,
  localparam int unsigned FW       = hazard_pkg::fwd_w(LOAD_LAT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5*NSRC-1:0]  id_rs,
  input  logic [NSRC-1:0]    id_rs_used,
  input  logic [4:0]         id_rd,
  input  logic               id_we,
  input  logic               id_load,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [FW*NSRC-1:0] ex_fwd_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  // EX + (LOAD_LAT+1) memory stages + WB.
  localparam int unsigned DEPTH = LOAD_LAT + 3;

  tag_slot_t           slots [DEPTH];
  tag_slot_t           id_slot;
  logic                bubble;
  logic                accept;
  logic                stall_raw;
  logic [FW*NSRC-1:0]  sel_d;
  logic                ex_valid_q;
  logic [FW*NSRC-1:0]  ex_fwd_sel_q;

  function automatic logic slot_match(input tag_slot_t s, input logic [4:0] rs,
                                      input logic used, input logic vld);
    return s.valid && (s.rd == rs) && (s.rd != 5'd0) && used && vld;
  endfunction

  // Scan oldest to youngest so the youngest matching producer overwrites the select.
  always_comb begin
    stall_raw = 1'b0;
    sel_d     = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
        if (slot_match(slots[j], id_rs[5*k +: 5], id_rs_used[k], id_valid)) begin
          // Select names the stage the producer occupies next cycle; WB leaves via regfile.
          sel_d[FW*k +: FW] = (j == int'(DEPTH) - 1) ? FW'(FWD_REGFILE) : FW'(j + 1);
          // Load data is not ready until the producer has left MEM[LOAD_LAT-1].
          if (slots[j].load && (j <= int'(LOAD_LAT))) begin
            stall_raw = 1'b1;
          end
        end
      end
    end
  end

  // Flush kills the ID instruction, so a hazard against it is moot.
  assign stall  = stall_raw & ~flush;
  assign bubble = stall | flush;
  assign accept = id_valid & ~bubble;

  assign id_slot = '{valid: id_valid & id_we, rd: id_rd, load: id_load};

  haz_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_tag_pipe (
    .clk_i    (clk),
    .rst_ni   (rst),
    .bubble_i (bubble),
    .slot_i   (id_slot),
    .slots_o  (slots)
  );

  // EX-stage status registers, loaded with a bubble on stall or flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_fwd_sel_q <= '0;
    end else begin
      ex_valid_q   <= accept;
      ex_fwd_sel_q <= accept ? sel_d : '0;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_fwd_sel = ex_fwd_sel_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: one instance with LOAD_LAT=0 and one with LOAD_LAT=2 share
// the ID inputs; both are compared every cycle against a history-based reference model.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        id_load;
  logic        flush;

  logic        stall0, exv0;
  logic [3:0]  sel0;
  logic        stall2, exv2;
  logic [5:0]  sel2;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] scnt0, fcnt0, scnt2, fcnt2;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit #(.NSRC(2), .LOAD_LAT(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_load    (id_load),
    .flush      (flush),
    .stall      (stall0),
    .ex_valid   (exv0),
    .ex_fwd_sel (sel0)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt  (scnt0),
    .flush_cnt  (fcnt0)
`endif
  );

  hazard_fwd_unit #(.NSRC(2), .LOAD_LAT(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_load    (id_load),
    .flush      (flush),
    .stall      (stall2),
    .ex_valid   (exv2),
    .ex_fwd_sel (sel2)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt  (scnt2),
    .flush_cnt  (fcnt2)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: history of instructions that entered EX, indexed by age in cycles
  // (age 0 = EX now, age LAT+2 = WB now). Index d: 0 -> LOAD_LAT=0, 1 -> LOAD_LAT=2.
  bit          h_wr  [2][5];
  int          h_rd  [2][5];
  bit          h_ld  [2][5];
  bit          m_stall [2];
  int          m_sel   [2][2];
  bit          m_exv   [2];
  int          m_exsel [2][2];
  int unsigned m_scnt  [2];
  int unsigned m_fcnt;
  bit          obs_stall0, obs_stall2;

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 5; a++) begin
        h_wr[d][a] = 0; h_rd[d][a] = 0; h_ld[d][a] = 0;
      end
      m_exv[d] = 0; m_exsel[d][0] = 0; m_exsel[d][1] = 0; m_scnt[d] = 0;
    end
    m_fcnt = 0;
  endtask

  // Hazard and select rules applied to the current ID inputs.
  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int  lat = lat_of(d);
      bit  st  = 0;
      for (int k = 0; k < 2; k++) begin
        int rs   = int'((id_rs >> (5 * k)) & 10'h1f);
        bit used = id_rs_used[k];
        bit found = 0;
        m_sel[d][k] = 0;
        for (int a = 0; a <= lat + 2; a++) begin
          bit hit = id_valid && used && h_wr[d][a] && (h_rd[d][a] == rs) && (rs != 0);
          if (hit && !found) begin
            found = 1;
            // Age a now -> age a+1 next cycle: EX->MEM0 is code 1, MEMi is i+2, WB is regfile.
            m_sel[d][k] = (a == lat + 2) ? 0 : a + 1;
          end
          // Load result unavailable while the load is younger than MEM[lat].
          if (hit && h_ld[d][a] && (a <= lat)) st = 1;
        end
      end
      m_stall[d] = st && !flush;
    end
  endtask

  task automatic model_clock();
    if (!rst) begin
      model_clear();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit take = id_valid && !m_stall[d] && !flush;
        m_exv[d] = take;
        for (int k = 0; k < 2; k++) m_exsel[d][k] = take ? m_sel[d][k] : 0;
        for (int a = 4; a > 0; a--) begin
          h_wr[d][a] = h_wr[d][a-1]; h_rd[d][a] = h_rd[d][a-1]; h_ld[d][a] = h_ld[d][a-1];
        end
        h_wr[d][0] = take && id_we;
        h_rd[d][0] = int'(id_rd);
        h_ld[d][0] = take && id_load;
        if (m_stall[d] && m_scnt[d] != 32'hFFFF_FFFF) m_scnt[d]++;
      end
      if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end
  endtask

  // One clock with ID inputs held: check stall, clock the model, check EX registers.
  task automatic step();
    logic [31:0] e0, e2;
    #1;
    model_eval();
    obs_stall0 = stall0;
    obs_stall2 = stall2;
    check("stall_l0", 32'(stall0), 32'(m_stall[0]));
    check("stall_l2", 32'(stall2), 32'(m_stall[1]));
    @(posedge clk);
    model_clock();
    #1;
    e0 = 32'((m_exsel[0][1] << 2) | m_exsel[0][0]);
    e2 = 32'((m_exsel[1][1] << 3) | m_exsel[1][0]);
    check("exv_l0", 32'(exv0), 32'(m_exv[0]));
    check("exv_l2", 32'(exv2), 32'(m_exv[1]));
    check("sel_l0", 32'(sel0), e0);
    check("sel_l2", 32'(sel2), e2);
`ifdef HAZ_PERF_CNT_EN
    check("scnt_l0", scnt0, m_scnt[0]);
    check("scnt_l2", scnt2, m_scnt[1]);
    check("fcnt_l0", fcnt0, m_fcnt);
    check("fcnt_l2", fcnt2, m_fcnt);
`endif
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs0, input int rs1, input logic [1:0] used,
                        input int rd, input bit we, input bit ld, input bit fl);
    id_valid   = v;
    id_rs      = {5'(rs1), 5'(rs0)};
    id_rs_used = used;
    id_rd      = 5'(rd);
    id_we      = we;
    id_load    = ld;
    flush      = fl;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    bit any_stall;

    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    model_clear();
    #1;
    check("rst_exv_l0", 32'(exv0), 32'd0);
    check("rst_exv_l2", 32'(exv2), 32'd0);
    check("rst_sel_l0", 32'(sel0), 32'd0);
    check("rst_sel_l2", 32'(sel2), 32'd0);
    @(negedge clk);
    check("rst_stall_l0", 32'(stall0), 32'd0);
    check("rst_stall_l2", 32'(stall2), 32'd0);
    rst = 1'b1;

    // LOAD_LAT=0 back-to-back load-use: lw x15; and x7,x15,x4.
    set_id(1, 0, 0, 2'b01, 15, 1, 1, 0);
    step();
    set_id(1, 15, 4, 2'b11, 7, 1, 0, 0);
    step();
    check("b2b_stall_first", 32'(obs_stall0), 32'd1);
    check("b2b_bubble", 32'(exv0), 32'd0);
    step();
    check("b2b_stall_second", 32'(obs_stall0), 32'd0);
    check("b2b_exv", 32'(exv0), 32'd1);
    check("b2b_sel", 32'(sel0), 32'h2);
    idle();
    step();

    // LOAD_LAT=0 distant load: lw x15; add x2,x0,x0; addi x4,x0,15; and x7,x15,x4.
    do_reset();
    any_stall = 0;
    set_id(1, 0, 0, 2'b01, 15, 1, 1, 0); step(); any_stall |= obs_stall0;
    set_id(1, 0, 0, 2'b11, 2, 1, 0, 0);  step(); any_stall |= obs_stall0;
    set_id(1, 0, 0, 2'b01, 4, 1, 0, 0);  step(); any_stall |= obs_stall0;
    set_id(1, 15, 4, 2'b11, 7, 1, 0, 0); step(); any_stall |= obs_stall0;
    check("dist_no_stall", 32'(any_stall), 32'd0);
    check("dist_exv", 32'(exv0), 32'd1);
    check("dist_sel", 32'(sel0), 32'h4);
    idle();
    step();

    // LOAD_LAT=2: lw x5; add x6,x5,x5 held in ID until released.
    do_reset();
    set_id(1, 0, 0, 2'b01, 5, 1, 1, 0);
    step();
    set_id(1, 5, 5, 2'b11, 6, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_stall2) n++;
      else break;
    end
    check("l2_stall_cycles", 32'(n), 32'd3);
    check("l2_exv", 32'(exv2), 32'd1);
    check("l2_sel", 32'(sel2), 32'h24);
    idle();
    step();

    // Youngest producer wins: addi x3; addi x3; add x4,x3,x0.
    do_reset();
    set_id(1, 0, 0, 2'b01, 3, 1, 0, 0); step();
    set_id(1, 0, 0, 2'b01, 3, 1, 0, 0); step();
    set_id(1, 3, 0, 2'b11, 4, 1, 0, 0); step();
    check("young_sel_l0", 32'(sel0), 32'h1);
    check("young_sel_l2", 32'(sel2), 32'h1);
    // lw x0 then a use of x0 never stalls.
    set_id(1, 0, 0, 2'b01, 0, 1, 1, 0); step();
    set_id(1, 0, 0, 2'b11, 9, 1, 0, 0); step();
    check("x0_stall_l0", 32'(obs_stall0), 32'd0);
    check("x0_stall_l2", 32'(obs_stall2), 32'd0);
    idle();
    step();

    // Flush in the same cycle as a load-use hazard.
    do_reset();
    set_id(1, 0, 0, 2'b01, 15, 1, 1, 0); step();
    set_id(1, 15, 4, 2'b11, 7, 1, 0, 1); step();
    check("flush_stall", 32'(obs_stall0), 32'd0);
    check("flush_exv", 32'(exv0), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("flush_cnt", fcnt0, 32'd1);
`endif
    idle();
    step();

    // Reset in the middle of a LOAD_LAT=2 stall.
    do_reset();
    set_id(1, 0, 0, 2'b01, 5, 1, 1, 0); step();
    set_id(1, 5, 5, 2'b11, 6, 1, 0, 0); step(); step();
    check("mid_stall_active", 32'(obs_stall2), 32'd1);
    rst = 1'b0;
    step();
    check("mid_rst_exv", 32'(exv2), 32'd0);
    check("mid_rst_sel", 32'(sel2), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("mid_rst_scnt", scnt2, 32'd0);
`endif
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall2), 32'd0);
    step();
    idle();
    step();

    // Random traffic over a small register set to make hazards frequent.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
